// File: rtl/uart_tx_fifo.sv
// Byte FIFO and send sequencer that feeds uart_tx over its data/data_ready/done handshake.
// Optional macro UART_TX_FIFO_CRLF_EN inserts a CR before any LF not already preceded by one.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        tx_data,
  output logic              tx_data_ready,
  input  logic              tx_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        cyc_cnt;
  logic              wr_acc;
  logic              pop;
  logic [7:0]        head;
  logic [7:0]        load_byte;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign busy   = (state != IDLE);
  assign head   = mem[rd_ptr];
  // full is the pre-pop occupancy, so a write in the popping cycle is still dropped
  assign wr_acc = wr_en && !full;

`ifdef UART_TX_FIFO_CRLF_EN
  logic last_cr;
  logic ins_cr;

  assign ins_cr    = (head == 8'h0A) && !last_cr;
  assign pop       = (state == LOAD) && !ins_cr;
  assign load_byte = ins_cr ? 8'h0D : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cr <= 1'b0;
    end else if (state == LOAD) begin
      last_cr <= (load_byte == 8'h0D);
    end
  end
`else
  assign pop       = (state == LOAD);
  assign load_byte = head;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !pop) begin
        count <= count + 1'b1;
      end else if (!wr_acc && pop) begin
        count <= count - 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (state == LOAD) begin
        tx_data <= load_byte;
      end
    end
  end

  // Handshake: tx_data_ready is high for exactly two cycles while tx_data is stable;
  // uart_tx acknowledges by dropping tx_done, and raising it again ends the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_data_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && tx_done) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = START;
      end
      START: begin
        tx_data_ready = 1'b1;
        if (cyc_cnt == 2'd1) begin
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Timeout covers uart_tx variants whose done never drops
        if (!tx_done || cyc_cnt == 2'd3) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx handshake model.
// Build with UART_TX_FIFO_CRLF_EN defined to check CR insertion.
module tb_uart_tx_fifo;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int BUSY_CYCLES = 20;
`ifdef UART_TX_FIFO_CRLF_EN
  localparam int CR_EXTRA = 1;
`else
  localparam int CR_EXTRA = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      wr_data = 8'h00;
  logic            wr_en = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      tx_data;
  logic            tx_data_ready;
  logic            tx_done;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
`ifdef UART_TX_FIFO_CRLF_EN
  logic exp_last_cr = 1'b0;
`endif

  // uart_tx model controls
  logic       block = 1'b0;
  logic       tie = 1'b0;
  logic       hold = 1'b0;
  logic       stab_en = 1'b1;
  logic       model_busy = 1'b0;
  logic       model_done = 1'b1;
  logic [7:0] latched = 8'h00;
  int         left = 0;
  int         rx_cnt = 0;

  int   cyc = 0;
  int   done_cyc = 0;
  logic done_seen = 1'b0;
  logic gap_en = 1'b0;
  int   pulses = 0;
  int   rise_cyc = 0;
  int   hi_run = 0;
  logic rdy_q = 1'b0;

  int t0;
  int t1;
  int p_save;
  int rx_save;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_done = block ? 1'b0 : (tie ? 1'b1 : model_done);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
    if (b == 8'h0A && !exp_last_cr) exp_q.push_back(8'h0D);
    exp_last_cr = (b == 8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic reset_exp();
    exp_q.delete();
`ifdef UART_TX_FIFO_CRLF_EN
    exp_last_cr = 1'b0;
`endif
  endtask

  // driver: one accepted byte per call, wr_en left high for back-to-back use
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    push_exp(b);
    step();
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while (!(empty && !busy && model_done && !model_busy) && n < budget) begin
      step();
      n++;
    end
    chk(tag, n < budget, 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_pulse_n(input int target, output int c);
    int n = 0;
    while (pulses < target && n < 300) begin
      step();
      n++;
    end
    chk("pulse_wait", pulses >= target, 1);
    c = rise_cyc;
  endtask

  // behavioural uart_tx: latch on ready, hold done low for BUSY_CYCLES
  always @(negedge clk) begin
    if (!tie && !model_busy && tx_data_ready) begin
      latched    = tx_data;
      model_busy = 1'b1;
      model_done = 1'b0;
      left       = BUSY_CYCLES;
    end else if (model_busy) begin
      if (stab_en) chk("tx_data_stable", tx_data, latched);
      if (left > 0) left--;
      if (left == 0 && !hold) begin
        model_busy = 1'b0;
        model_done = 1'b1;
        rx_cnt++;
        done_cyc   = cyc;
        done_seen  = 1'b1;
      end
    end
  end

  // scoreboard: every ready pulse must present the next expected byte for two cycles
  always @(negedge clk) begin
    if (tx_data_ready && !rdy_q) begin
      pulses++;
      rise_cyc = cyc;
      hi_run   = 1;
      chk("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
      if (gap_en && done_seen) chk("done_to_ready_gap", cyc - done_cyc, 3);
      done_seen = 1'b0;
    end else if (tx_data_ready) begin
      hi_run++;
    end else if (rdy_q) begin
      chk("ready_width", hi_run, 2);
    end
    rdy_q = tx_data_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ready", tx_data_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // single byte: ready rises on the LOAD->START edge, third edge counting the write
    write_byte(8'hA5);
    wr_en = 1'b0;
    chk("lat_count", count, 1);
    chk("lat_empty", empty, 0);
    chk("lat_busy_idle", busy, 0);
    chk("lat_ready_e0", tx_data_ready, 0);
    step();
    chk("lat_busy_load", busy, 1);
    chk("lat_ready_e1", tx_data_ready, 0);
    step();
    chk("lat_ready_e2", tx_data_ready, 1);
    chk("lat_tx_data", tx_data, 8'hA5);
    chk("lat_count_pop", count, 0);
    chk("lat_empty_pop", empty, 1);
    wait_drained("single_drain", 200);
    chk("single_rx_cnt", rx_cnt, 1);

    // burst of 16 while the sequencer is stalled in IDLE
    block = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    wr_en = 1'b0;
    chk("burst_full", full, 1);
    chk("burst_count", count, 16);
    rx_save   = rx_cnt;
    done_seen = 1'b0;
    gap_en    = 1'b1;
    block     = 1'b0;
    wait_pulse_n(pulses + 1, t0);
    chk("burst_first_pop", count, 15);
    wait_drained("burst_drain", 1500);
    gap_en = 1'b0;
    chk("burst_count_end", count, 0);
    chk("burst_rx_cnt", rx_cnt - rx_save, 16 + CR_EXTRA);

    // overflow while the sequencer sits in WAIT_DONE
    hold = 1'b1;
    write_byte(8'h55);
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("ovf_busy", busy, 1);
    chk("ovf_empty", empty, 1);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        write_byte(8'(8'h60 + i));
      end else begin
        wr_data = 8'h70;
        step();
      end
      if (i == 15) begin
        chk("ovf_full16", full, 1);
        chk("ovf_clear_before", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    ovf_clr = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h7F;
    step();
    ovf_clr = 1'b0;
    wr_en   = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count_kept", count, 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared2", overflow, 0);
    hold = 1'b0;
    wait_drained("ovf_drain", 1500);

    // write in the LOAD cycle at count 8
    block = 1'b1;
    for (int i = 0; i < 8; i++) write_byte(8'(8'h90 + i));
    wr_en = 1'b0;
    chk("wp_count8", count, 8);
    block = 1'b0;
    step();
    write_byte(8'h98);
    wr_en = 1'b0;
    chk("wp_count_same", count, 8);
    chk("wp_ready", tx_data_ready, 1);
    wait_drained("wp_drain", 1000);

    // reset while uart_tx is mid-byte with bytes still queued
    block = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h81 + i));
    wr_en = 1'b0;
    block = 1'b0;
    wait_pulse_n(pulses + 1, t0);
    for (int i = 0; i < 5; i++) step();
    stab_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_data_ready, 0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_overflow", overflow, 0);
    reset_exp();
    p_save = pulses;
    step();
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 100 && !model_done; n++) step();
    chk("mid_rst_model_done", model_done, 1);
    for (int i = 0; i < 20; i++) step();
    chk("mid_rst_no_resend", pulses, p_save);
    chk("mid_rst_idle", busy, 0);
    stab_en = 1'b1;

    // done tied high: WAIT_BUSY exits on its timeout
    tie    = 1'b1;
    p_save = pulses;
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    wr_en = 1'b0;
    wait_pulse_n(p_save + 1, t0);
    wait_pulse_n(p_save + 2, t1);
    chk("tie_period_1", t1 - t0, 9);
    t0 = t1;
    wait_pulse_n(p_save + 3, t1);
    chk("tie_period_2", t1 - t0, 9);
    wait_drained("tie_drain", 200);
    chk("tie_pulses", pulses - p_save, 3);
    tie = 1'b0;

    // LF handling
    block  = 1'b1;
    p_save = pulses;
    write_byte(8'h41);
    write_byte(8'h0A);
    write_byte(8'h0D);
    write_byte(8'h0A);
    wr_en = 1'b0;
    block = 1'b0;
    wait_drained("crlf_drain", 1000);
    chk("crlf_pulses", pulses - p_save, 4 + CR_EXTRA);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
